ssit: RTL and testbench
=======================

Name: ssit

Overview:
- Store Set ID Table: a PC-indexed table that maps each load/store instruction to a store set ID (SSID). It sits in rename, directly upstream of the last-fetched-store table.
- Each cycle it answers up to 4 lookups from the rename bundle. Its ssid/valid outputs drive the LFST ssid/valid inputs.
- It is trained by memory-order violations reported from the load/store unit, using store-set merge rules.
- It is cleared periodically so that stale sets age out.

Parameters:
- INDEX_BITS, 10, log2 of table entries (1024 entries); index = pc[INDEX_BITS+1:2].
- SSID_BITS, 7, SSID width; matches the LFST's 128 sets.
- CLEAR_PERIOD, 16384, cycles between global invalidations; must be ≥2.

Ports:
- clock  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- pc0_in..pc3_in  input  64  PCs of bundle slots 0-3.
- mem0_in..mem3_in  input  1  slot holds a load or store (lookup requested).
- ssid0_out..ssid3_out  output  7  SSID stored at slot's index.
- valid0_out..valid3_out  output  1  slot has a valid SSID and mem*_in is set.
- viol_in  input  1  memory-order violation report valid.
- viol_load_pc_in  input  64  PC of the violating load.
- viol_store_pc_in  input  64  PC of the store it depended on.
- clear_pulse_out  output  1  high during the cycle the global clear is applied (for LFST flush/debug).

Behaviour:
- Storage:
  - ssid_f[2^INDEX_BITS] holds SSID_BITS each; vld_f[2^INDEX_BITS] holds 1 bit each.
  - alloc_f (SSID_BITS) is the next fresh SSID.
  - clr_cnt_f (ceil log2 CLEAR_PERIOD bits) is the clear counter.
- Reset (async, reset_n low):
  - vld_f, ssid_f, alloc_f and clr_cnt_f all go to 0.
  - Outputs: ssid*_out=0, valid*_out=0, clear_pulse_out=0.
  - Reset mid-violation discards that violation.
- Lookup (combinational, 0 latency):
  - ssidN_out = ssid_f[idxN].
  - validN_out = vld_f[idxN] && memN_in.
  - There is no bypass: a lookup in the same cycle as a violation write or a clear sees pre-edge state. The effect is visible from the next cycle.
- Violation training (single cycle; writes at the posedge after viol_in=1):
  - Let Li/Si = load/store indices, Lv/Sv = vld_f at those indices, Ls/Ss = ssid_f at those indices.
  - Neither valid: both entries ← alloc_f, both vld←1; alloc_f ← alloc_f+1, wrapping mod 2^SSID_BITS (127→0).
  - Only load valid: store entry ← Ls, vld←1.
  - Only store valid: load entry ← Ss, vld←1.
  - Both valid, Ls≠Ss: both entries ← min(Ls,Ss). Both valid, equal: no write.
  - Li==Si: treated as one entry; same rules apply, and only one allocation occurs when neither is valid.
  - alloc_f advances only in the neither-valid case.
  - One violation is accepted per cycle; there is no backpressure. The LSU serialises reports.
- Periodic clear:
  - clr_cnt_f increments every cycle.
  - At CLEAR_PERIOD-1 it wraps to 0, and on that same edge all vld_f←0. clear_pulse_out=1 in the cycle where clr_cnt_f==CLEAR_PERIOD-1.
  - ssid_f and alloc_f are not cleared.
  - A violation in the clear cycle: the clear is applied first, then the violation writes land. The violation's entries end valid and all others invalid. The violation's merge decision uses pre-clear vld/ssid values.
- A pipeline flush does not affect this table; it is persistent predictor state.

Test Plan:
- Reset, then lookup pc0=0x1000 with mem0=1 → valid0_out=0, ssid0_out=0; clear_pulse_out=0.
- viol load 0x1000, store 0x2000, both invalid → next cycle lookups of both give valid=1, ssid=0; a second fresh violation (0x3000/0x4000) gets ssid=1.
- Store 0x2000 has ssid 0; violation with new load 0x5000 → load 0x5000 gets ssid 0; alloc_f unchanged (next fresh = 2).
- Load set ssid 5, store set ssid 3, violation → both entries read 3 next cycle. Same lookup in the violation cycle still reads 5.
- CLEAR_PERIOD=16: populate entries; at cycle 15 clear_pulse_out=1 → next cycle all valid*_out=0. A violation in cycle 15 leaves only its two entries valid.
- alloc wrap: 128 fresh violations with distinct PCs → the 129th allocates ssid 0; mem*_in=0 forces valid*_out=0 even for a valid entry.

Source files
------------

// File: rtl/ssit.sv
// Store Set ID Table: PC-indexed map from load/store to store set ID, trained by
// memory-order violations and periodically invalidated so stale sets age out.
module ssit #(
    parameter int unsigned INDEX_BITS   = 10,
    parameter int unsigned SSID_BITS    = 7,
    parameter int unsigned CLEAR_PERIOD = 16384
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [63:0]          pc0_in,
    input  logic [63:0]          pc1_in,
    input  logic [63:0]          pc2_in,
    input  logic [63:0]          pc3_in,
    input  logic                 mem0_in,
    input  logic                 mem1_in,
    input  logic                 mem2_in,
    input  logic                 mem3_in,
    output logic [SSID_BITS-1:0] ssid0_out,
    output logic [SSID_BITS-1:0] ssid1_out,
    output logic [SSID_BITS-1:0] ssid2_out,
    output logic [SSID_BITS-1:0] ssid3_out,
    output logic                 valid0_out,
    output logic                 valid1_out,
    output logic                 valid2_out,
    output logic                 valid3_out,
    input  logic                 viol_in,
    input  logic [63:0]          viol_load_pc_in,
    input  logic [63:0]          viol_store_pc_in,
    output logic                 clear_pulse_out
);
    localparam int unsigned Entries = 2 ** INDEX_BITS;
    localparam int unsigned CntBits = $clog2(CLEAR_PERIOD);
    localparam logic [CntBits-1:0] CntLast = CntBits'(CLEAR_PERIOD - 1);

    logic [SSID_BITS-1:0]  ssid_q [Entries];
    logic [Entries-1:0]    vld_q, vld_d;
    logic [SSID_BITS-1:0]  alloc_q, alloc_d;
    logic [CntBits-1:0]    clr_cnt_q, clr_cnt_d;
    logic                  clear;

    logic [INDEX_BITS-1:0] idx0, idx1, idx2, idx3;
    logic [INDEX_BITS-1:0] li, si;
    logic                  lv, sv;
    logic [SSID_BITS-1:0]  ls, ss;
    logic                  wr_l, wr_s;
    logic [SSID_BITS-1:0]  wr_val;

    // Only the word-index bits of each PC select an entry.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc0_in[63:INDEX_BITS+2], pc0_in[1:0],
                              pc1_in[63:INDEX_BITS+2], pc1_in[1:0],
                              pc2_in[63:INDEX_BITS+2], pc2_in[1:0],
                              pc3_in[63:INDEX_BITS+2], pc3_in[1:0],
                              viol_load_pc_in[63:INDEX_BITS+2], viol_load_pc_in[1:0],
                              viol_store_pc_in[63:INDEX_BITS+2], viol_store_pc_in[1:0]};

    assign idx0 = pc0_in[INDEX_BITS+1:2];
    assign idx1 = pc1_in[INDEX_BITS+1:2];
    assign idx2 = pc2_in[INDEX_BITS+1:2];
    assign idx3 = pc3_in[INDEX_BITS+1:2];

    // Lookups read pre-edge state; no bypass from same-cycle training or clear.
    assign ssid0_out  = ssid_q[idx0];
    assign ssid1_out  = ssid_q[idx1];
    assign ssid2_out  = ssid_q[idx2];
    assign ssid3_out  = ssid_q[idx3];
    assign valid0_out = vld_q[idx0] & mem0_in;
    assign valid1_out = vld_q[idx1] & mem1_in;
    assign valid2_out = vld_q[idx2] & mem2_in;
    assign valid3_out = vld_q[idx3] & mem3_in;

    assign clear           = (clr_cnt_q == CntLast);
    assign clear_pulse_out = clear;

    assign li = viol_load_pc_in[INDEX_BITS+1:2];
    assign si = viol_store_pc_in[INDEX_BITS+1:2];
    assign lv = vld_q[li];
    assign sv = vld_q[si];
    assign ls = ssid_q[li];
    assign ss = ssid_q[si];

    // Store-set merge; when li == si both views agree, so one allocation at most.
    always_comb begin
        wr_l    = 1'b0;
        wr_s    = 1'b0;
        wr_val  = alloc_q;
        alloc_d = alloc_q;
        if (viol_in) begin
            case ({lv, sv})
                2'b00: begin
                    wr_l    = 1'b1;
                    wr_s    = 1'b1;
                    alloc_d = alloc_q + 1'b1;
                end
                2'b10: begin
                    wr_s   = 1'b1;
                    wr_val = ls;
                end
                2'b01: begin
                    wr_l   = 1'b1;
                    wr_val = ss;
                end
                default: begin
                    if (ls != ss) begin
                        wr_l   = 1'b1;
                        wr_s   = 1'b1;
                        wr_val = (ls < ss) ? ls : ss;
                    end
                end
            endcase
        end
    end

    // Clear first, then the violation's entries are (re)marked valid.
    always_comb begin
        vld_d = clear ? '0 : vld_q;
        if (viol_in) begin
            vld_d[li] = 1'b1;
            vld_d[si] = 1'b1;
        end
        clr_cnt_d = clear ? '0 : clr_cnt_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < Entries; i++) begin
                ssid_q[i] <= '0;
            end
            vld_q     <= '0;
            alloc_q   <= '0;
            clr_cnt_q <= '0;
        end else begin
            vld_q     <= vld_d;
            alloc_q   <= alloc_d;
            clr_cnt_q <= clr_cnt_d;
            if (wr_l) ssid_q[li] <= wr_val;
            if (wr_s) ssid_q[si] <= wr_val;
        end
    end

endmodule

// File: tb/tb_ssit.sv
// Scoreboard bench for ssit: stimulus queues expected lookup results, a negedge
// monitor drains and compares them, and checks clear_pulse_out every cycle.
module tb_ssit;
    localparam int unsigned ClearPeriod = 16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] pc [4];
    logic        mem [4];
    logic [6:0]  ssid_o [4];
    logic        valid_o [4];
    logic        clear_pulse;
    logic        viol;
    logic [63:0] vl, vs;

    typedef struct {
        string      name;
        int         slot;
        logic       ev;
        logic [6:0] es;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cnt = 0;

    ssit #(
        .INDEX_BITS(10),
        .SSID_BITS(7),
        .CLEAR_PERIOD(ClearPeriod)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .pc0_in(pc[0]),
        .pc1_in(pc[1]),
        .pc2_in(pc[2]),
        .pc3_in(pc[3]),
        .mem0_in(mem[0]),
        .mem1_in(mem[1]),
        .mem2_in(mem[2]),
        .mem3_in(mem[3]),
        .ssid0_out(ssid_o[0]),
        .ssid1_out(ssid_o[1]),
        .ssid2_out(ssid_o[2]),
        .ssid3_out(ssid_o[3]),
        .valid0_out(valid_o[0]),
        .valid1_out(valid_o[1]),
        .valid2_out(valid_o[2]),
        .valid3_out(valid_o[3]),
        .viol_in(viol),
        .viol_load_pc_in(vl),
        .viol_store_pc_in(vs),
        .clear_pulse_out(clear_pulse)
    );

    always #5 clock = ~clock;

    // Model of the clear counter; expected pulse when it sits at the last count.
    task automatic step();
        @(posedge clock);
        if (reset_n) cnt = (cnt + 1) % ClearPeriod;
        else cnt = 0;
        #1;
        for (int i = 0; i < 4; i++) mem[i] = 1'b0;
        viol = 1'b0;
    endtask

    task automatic look(input string name, input int slot, input logic [63:0] p,
                        input logic m, input logic ev, input logic [6:0] es);
        exp_t e;
        pc[slot]  = p;
        mem[slot] = m;
        e.name = name;
        e.slot = slot;
        e.ev   = ev;
        e.es   = es;
        sb.push_back(e);
    endtask

    task automatic violate(input logic [63:0] lp, input logic [63:0] sp);
        viol = 1'b1;
        vl   = lp;
        vs   = sp;
    endtask

    task automatic sync_to(input int n);
        int k = 0;
        while (cnt != n && k < 40) begin
            step();
            k++;
        end
        if (cnt != n) begin
            n_checks++;
            n_fail++;
            $display("FAIL sync_to: counter model at %0d, wanted %0d", cnt, n);
        end
    endtask

    function automatic logic [63:0] pc_of(input int idx);
        return 64'(idx) << 2;
    endfunction

    always @(negedge clock) begin
        exp_t e;
        logic exp_pulse;
        exp_pulse = reset_n && (cnt == ClearPeriod - 1);
        n_checks++;
        if (clear_pulse !== exp_pulse) begin
            n_fail++;
            $display("FAIL clear_pulse (cnt=%0d): got %0b, expected %0b",
                     cnt, clear_pulse, exp_pulse);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (valid_o[e.slot] !== e.ev || ssid_o[e.slot] !== e.es) begin
                n_fail++;
                $display("FAIL %s slot%0d: got valid=%0b ssid=%0d, expected valid=%0b ssid=%0d",
                         e.name, e.slot, valid_o[e.slot], ssid_o[e.slot], e.ev, e.es);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        viol = 1'b0;
        vl   = '0;
        vs   = '0;
        for (int i = 0; i < 4; i++) begin
            pc[i]  = '0;
            mem[i] = 1'b0;
        end

        step();
        look("in_reset", 0, 64'h1000, 1'b1, 1'b0, 7'd0);
        step();
        reset_n = 1'b1;
        look("post_reset", 0, 64'h1000, 1'b1, 1'b0, 7'd0);
        step();

        sync_to(0);
        // c0: fresh pair gets ssid 0
        violate(64'h100, 64'h200);
        step();
        // c1
        look("fresh0_load", 0, 64'h100, 1'b1, 1'b1, 7'd0);
        look("fresh0_store", 1, 64'h200, 1'b1, 1'b1, 7'd0);
        look("alias_idx", 2, 64'h1100, 1'b1, 1'b1, 7'd0);
        violate(64'h300, 64'h400);
        step();
        // c2: only store valid -> load joins ssid 0
        look("fresh1_load", 0, 64'h300, 1'b1, 1'b1, 7'd1);
        look("fresh1_store", 1, 64'h400, 1'b1, 1'b1, 7'd1);
        violate(64'h500, 64'h200);
        step();
        // c3
        look("store_valid_join", 0, 64'h500, 1'b1, 1'b1, 7'd0);
        violate(64'h600, 64'h700);
        step();
        // c4: alloc did not advance on the join
        look("fresh2_load", 0, 64'h600, 1'b1, 1'b1, 7'd2);
        look("fresh2_store", 3, 64'h700, 1'b1, 1'b1, 7'd2);
        violate(64'h800, 64'h900);
        step();
        // c5, c6
        violate(64'hA00, 64'hB00);
        step();
        violate(64'hC00, 64'hD00);
        step();
        // c7: load set 5, store set 3; same-cycle lookup sees old value
        look("merge_same_cycle", 0, 64'hC00, 1'b1, 1'b1, 7'd5);
        violate(64'hC00, 64'h800);
        step();
        // c8
        look("merge_load_min", 0, 64'hC00, 1'b1, 1'b1, 7'd3);
        look("merge_store_min", 1, 64'h800, 1'b1, 1'b1, 7'd3);
        look("merge_untouched", 2, 64'hD00, 1'b1, 1'b1, 7'd5);
        violate(64'h100, 64'h900);
        step();
        // c9: load smaller (0) wins
        look("merge2_store", 0, 64'h900, 1'b1, 1'b1, 7'd0);
        look("merge2_load", 1, 64'h100, 1'b1, 1'b1, 7'd0);
        violate(64'hE00, 64'hE00);
        step();
        // c10: same index allocates once
        look("same_idx", 0, 64'hE00, 1'b1, 1'b1, 7'd6);
        violate(64'hF00, 64'hF80);
        step();
        // c11
        look("after_same_idx", 0, 64'hF00, 1'b1, 1'b1, 7'd7);
        violate(64'h100, 64'h104);
        step();
        // c12: only load valid -> store joins ssid 0
        look("load_valid_join", 0, 64'h104, 1'b1, 1'b1, 7'd0);
        look("mem_gate", 1, 64'h100, 1'b0, 1'b0, 7'd0);
        violate(64'h100, 64'h200);
        step();
        // c13: equal sets, no write
        look("equal_no_write", 0, 64'h100, 1'b1, 1'b1, 7'd0);
        step();
        // c14
        look("pre_clear", 0, 64'h100, 1'b1, 1'b1, 7'd0);
        step();
        // c15: clear cycle with a violation
        look("clear_cycle_old", 0, 64'h300, 1'b1, 1'b1, 7'd1);
        violate(64'h140, 64'h100);
        step();
        // c16
        look("clear_viol_load", 0, 64'h140, 1'b1, 1'b1, 7'd0);
        look("clear_viol_store", 1, 64'h100, 1'b1, 1'b1, 7'd0);
        look("cleared_b1", 2, 64'h300, 1'b1, 1'b0, 7'd1);
        look("cleared_g1", 3, 64'hC00, 1'b1, 1'b0, 7'd3);
        step();

        // alloc is 8 here; 120 fresh pairs use 8..127
        for (int i = 0; i < 120; i++) begin
            violate(pc_of(512 + 2 * i), pc_of(513 + 2 * i));
            step();
        end
        look("alloc_127_load", 0, pc_of(750), 1'b1, 1'b1, 7'd127);
        look("alloc_127_store", 1, pc_of(751), 1'b1, 1'b1, 7'd127);
        violate(pc_of(800), pc_of(801));
        step();
        look("alloc_wrap_load", 0, pc_of(800), 1'b1, 1'b1, 7'd0);
        look("alloc_wrap_store", 1, pc_of(801), 1'b1, 1'b1, 7'd0);
        look("mem_gate_127", 2, pc_of(750), 1'b0, 1'b0, 7'd127);
        step();

        // Reset lands mid-violation; the violation must be dropped
        violate(pc_of(900), pc_of(901));
        #2;
        reset_n = 1'b0;
        cnt = 0;
        step();
        reset_n = 1'b1;
        look("rst_drop_viol", 0, pc_of(900), 1'b1, 1'b0, 7'd0);
        look("rst_ssid_750", 1, pc_of(750), 1'b1, 1'b0, 7'd0);
        look("rst_ssid_801", 2, pc_of(801), 1'b1, 1'b0, 7'd0);
        violate(pc_of(900), pc_of(901));
        step();
        look("rst_alloc_zero", 0, pc_of(900), 1'b1, 1'b1, 7'd0);
        look("rst_alloc_zero_s", 1, pc_of(901), 1'b1, 1'b1, 7'd0);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
